// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Parallel-to-serial transmitter for the single-wire serial link.
//
// A word is accepted from local logic over a valid/ready handshake. It is then
// sent as one frame: a start bit (0), the data bits LSB-first, and a stop bit
// (1). Every bit cell lasts CLKS_PER_BIT clock cycles. The line idles high.
//
// Optional feature:
//   SERIAL_TX_PARITY_EN - when defined, an even-parity cell is inserted
//                         between the last data bit and the stop bit.
//
// Parameters:
//   DATA_WIDTH   - bits per word (>= 1)
//   CLKS_PER_BIT - clock cycles per bit cell (>= 1)
//
// Ports:
//   clk        in   single clock; all state updates on the rising edge
//   reset      in   asynchronous, active-high reset
//   tx_data    in   word to send; sampled only when the word is accepted
//   tx_valid   in   request to send tx_data
//   tx_ready   out  high only while idle (a word can be accepted)
//   tx_serial  out  registered serial line; idles high
//   tx_busy    out  high from the cycle after accept until the frame ends
//   tx_done    out  one-cycle pulse in the first idle cycle after the stop bit
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    // Counter widths, kept at least one bit wide so degenerate parameters
    // (one bit per word, one cycle per cell) still elaborate.
    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH   > 1) ? $clog2(DATA_WIDTH)   : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CYC_W-1:0]        cyc_r;
    logic [CYC_W-1:0]        cyc_next_s;
    logic [BIT_W-1:0]        bit_r;
    logic [BIT_W-1:0]        bit_next_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   shift_next_s;
    logic                    serial_r;
    logic                    serial_next_s;
    logic                    busy_r;
    logic                    busy_next_s;
    logic                    done_r;
    logic                    done_next_s;
    logic                    accept_s;
    logic                    cell_end_s;

`ifdef SERIAL_TX_PARITY_EN
    logic                    parity_r;
    logic                    parity_next_s;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    assign tx_ready   = (state_r == ST_IDLE);
    assign accept_s   = tx_valid && tx_ready;
    assign cell_end_s = (cyc_r == CYC_LAST);

    assign tx_serial  = serial_r;
    assign tx_busy    = busy_r;
    assign tx_done    = done_r;

    // Next-state, counter, shift register and line-value logic.
    always_comb begin
        state_next_s  = state_r;
        cyc_next_s    = cyc_r;
        bit_next_s    = bit_r;
        shift_next_s  = shift_r;
        done_next_s   = 1'b0;
        serial_next_s = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        parity_next_s = parity_r;
`endif

        case (state_r)
            ST_IDLE: begin
                cyc_next_s = {CYC_W{1'b0}};
                bit_next_s = {BIT_W{1'b0}};
                if (accept_s) begin
                    state_next_s  = ST_START;
                    shift_next_s  = tx_data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_next_s = even_parity(tx_data);
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (cell_end_s) begin
                    state_next_s = ST_DATA;
                    cyc_next_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_next_s = cyc_r + CYC_W'(1);
                end
            end

            ST_DATA: begin
                if (cell_end_s) begin
                    cyc_next_s   = {CYC_W{1'b0}};
                    shift_next_s = shift_r >> 1'b1;
                    if (bit_r == BIT_LAST) begin
                        bit_next_s = {BIT_W{1'b0}};
`ifdef SERIAL_TX_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        bit_next_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    cyc_next_s = cyc_r + CYC_W'(1);
                end
            end

`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (cell_end_s) begin
                    state_next_s = ST_STOP;
                    cyc_next_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_next_s = cyc_r + CYC_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (cell_end_s) begin
                    state_next_s = ST_IDLE;
                    cyc_next_s   = {CYC_W{1'b0}};
                    done_next_s  = 1'b1;
                end else begin
                    cyc_next_s = cyc_r + CYC_W'(1);
                end
            end

            default: begin
                state_next_s = ST_IDLE;
                cyc_next_s   = {CYC_W{1'b0}};
                bit_next_s   = {BIT_W{1'b0}};
            end
        endcase

        // The line register is loaded with the value belonging to the state
        // being entered, so the start bit appears on the very edge of accept.
        case (state_next_s)
            ST_IDLE:   serial_next_s = 1'b1;
            ST_START:  serial_next_s = 1'b0;
            ST_DATA:   serial_next_s = shift_next_s[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: serial_next_s = parity_next_s;
`endif
            ST_STOP:   serial_next_s = 1'b1;
            default:   serial_next_s = 1'b1;
        endcase

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // FSM state, cycle/bit counters and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cyc_r   <= {CYC_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            cyc_r   <= cyc_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the accepted word, captured once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_next_s;
        end
    end
`endif

    // Registered outputs: glitch-free line, busy flag and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            serial_r <= serial_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//
// Self-checking bench for serial_tx (DATA_WIDTH=8, CLKS_PER_BIT=4).
// It uses a table of words with hand-written expected frames, and
// hand-written sequences for back-to-back frames, ignored inputs and
// mid-frame reset. It also sends random words and checks them against a
// frame model built from the framing rules.
// When SERIAL_TX_PARITY_EN is defined, the expected frames include the
// parity cell.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NCELLS = DW + 3;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NCELLS = DW + 2;
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // cells without parity, first cell in the MSB
        logic       par;     // expected parity cell
    } vec_t;

    vec_t tbl [8];

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // Compare {serial, busy, ready, done} against an expected value.
    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {tx_serial, tx_busy, tx_ready, tx_done};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got serial/busy/ready/done=%b, want %b",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: the line value of cell idx for word d.
    function automatic logic model_cell(input logic [7:0] d, input int idx);
        int ones;
        ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return (((d >> (idx - 1)) & 8'd1) != 8'd0);
        if (PAR_EN && idx == DW + 1) begin
            for (int i = 0; i < DW; i++) ones += int'((d >> i) & 8'd1);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_frame(input logic [7:0] d);
        logic [15:0] e;
        e = 16'd0;
        for (int c = 0; c < NCELLS; c++) e[c] = model_cell(d, c);
        return e;
    endfunction

    // Expected cells of a table entry, cell index = bit index.
    function automatic logic [15:0] tbl_exp(input vec_t v);
        logic [15:0] e;
        e = 16'd0;
        for (int i = 0; i < 10; i++) e[i] = v.frame[9 - i];
        if (PAR_EN) begin
            e[DW + 1] = v.par;
            e[DW + 2] = 1'b1;
        end
        return e;
    endfunction

    // Send one word starting just after a rising edge, and check every cycle
    // of the frame plus the first idle cycle (tx_done).
    // keep_valid: leave tx_valid high and put next_d on tx_data after accept.
    // poke: frame cycle after which tx_data/tx_valid are disturbed (-1 = none).
    task automatic run_frame(input logic [7:0] d, input logic [15:0] exp,
                             input bit keep_valid, input logic [7:0] next_d,
                             input int poke, input string name);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int c = 0; c < NCELLS * CPB; c++) begin
            @(posedge clk);
            #1;
            check(name, {exp[c / CPB], 1'b1, 1'b0, 1'b0});
            if (c == 0) begin
                if (keep_valid) tx_data = next_d;
                else            tx_valid = 1'b0;
            end
            if (c == poke) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end
            if (poke >= 0 && c == poke + 1) tx_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "_done"}, 4'b1011);
    endtask

    // Check that the line stays idle for n cycles.
    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(name, 4'b1010);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] nd;
        bit         b;

        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
        tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[3] = '{8'h3C, 10'b0001111001, 1'b0};
        tbl[4] = '{8'h07, 10'b0111000001, 1'b1};
        tbl[5] = '{8'h03, 10'b0110000001, 1'b0};
        tbl[6] = '{8'h01, 10'b0100000001, 1'b1};
        tbl[7] = '{8'h80, 10'b0000000011, 1'b1};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_defaults", 4'b1010);
        idle_check(8, "idle_after_reset");

        // Table-driven frames, one idle cycle between them.
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].data, tbl_exp(tbl[i]), 1'b0, 8'h00, -1, "table");
            idle_check(1, "table_gap");
        end

        // Back-to-back: valid held high, second accept one cycle after the
        // first frame ends.
        run_frame(8'h00, model_frame(8'h00), 1'b1, 8'hFF, -1, "b2b_first");
        run_frame(8'hFF, model_frame(8'hFF), 1'b0, 8'h00, -1, "b2b_second");
        idle_check(2, "b2b_gap");

        // Inputs while busy are ignored: new data and a valid pulse at edge 12.
        run_frame(8'h3C, model_frame(8'h3C), 1'b0, 8'h00, 11, "ignored");
        idle_check(3 * CPB, "no_second_frame");

        // Mid-frame reset, two cycles into data bit 3.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midframe_reset_async", 4'b1010);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("midframe_reset_release", 4'b1010);
        idle_check(3 * CPB, "post_reset_idle");

        // Random words, sometimes sent back-to-back.
        d = 8'($urandom);
        for (int i = 0; i < 24; i++) begin
            nd = 8'($urandom);
            b  = (i != 23) && ($urandom_range(0, 1) == 1);
            run_frame(d, model_frame(d), b, nd, -1, "random");
            if (!b) idle_check($urandom_range(0, 3), "random_gap");
            d = nd;
        end
        idle_check(2, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
